// File: rtl/vdp_ports.sv
// vdp_ports: Z80-facing TMS9918-style data/control port front end.
// Owns the VRAM pointer, read-ahead buffer, R0-R7 and the frame flag.
module vdp_ports #(
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        cpu_din,
   output logic [7:0]        cpu_dout,
   input  logic              port_sel,
   input  logic              cpu_wr,
   input  logic              cpu_rd,
   output logic              busy,
   output logic [ADDR_W-1:0] vga_addr,
   output logic [7:0]        vga_din,
   output logic              vga_wr,
   output logic              vga_rd,
   input  logic [7:0]        vga_dout,
   input  logic              frame_n_int,
   output logic              n_int,
   output logic [1:0]        mode,
   output logic              video_on,
   output logic [13:0]       name_table_addr,
   output logic [13:0]       font_addr,
   output logic [13:0]       color_table_addr,
   output logic [13:0]       sprite_attr_addr,
   output logic [13:0]       sprite_pattern_table_addr,
   output logic [3:0]        text_color,
   output logic [3:0]        back_color
);

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      RD_ISSUE,
      RD_CAPTURE
   } state_t;

   state_t              state;
   logic [ADDR_W-1:0]   ptr;
   logic [7:0]          rd_buf;
   logic [7:0]          latch;
   logic                second;
   logic                flag;
   logic [7:0]          regs [0:7];
   logic                fr_q;
   logic                edge_q;
   logic [ADDR_W-1:0]   setup_addr;

   assign setup_addr = ADDR_W'({cpu_din[5:0], latch});

   // Frame pulse falling-edge detector, registered so F sets one cycle later
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fr_q   <= 1'b0;
         edge_q <= 1'b0;
      end else begin
         fr_q   <= frame_n_int;
         edge_q <= fr_q & ~frame_n_int;
      end
   end

   // Port decode, access sequencer and register file
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         ptr      <= '0;
         rd_buf   <= 8'h00;
         latch    <= 8'h00;
         second   <= 1'b0;
         flag     <= 1'b0;
         cpu_dout <= 8'h00;
         vga_addr <= '0;
         vga_din  <= 8'h00;
         vga_wr   <= 1'b0;
         vga_rd   <= 1'b0;
         for (int i = 0; i < 8; i++) regs[i] <= 8'h00;
      end else begin
         vga_wr <= 1'b0;
         vga_rd <= 1'b0;
         unique case (state)
            IDLE: begin
               if (cpu_wr && !port_sel) begin
                  second   <= 1'b0;
                  vga_addr <= ptr;
                  vga_din  <= cpu_din;
                  vga_wr   <= 1'b1;
                  rd_buf   <= cpu_din;
                  ptr      <= ptr + ADDR_W'(1);
                  state    <= WRITE;
               end else if (cpu_wr && port_sel) begin
                  if (!second) begin
                     latch  <= cpu_din;
                     second <= 1'b1;
                  end else begin
                     second <= 1'b0;
                     if (cpu_din[7]) begin
                        regs[cpu_din[2:0]] <= latch;
                     end else if (cpu_din[6]) begin
                        ptr <= setup_addr;
                     end else begin
                        vga_addr <= setup_addr;
                        vga_rd   <= 1'b1;
                        ptr      <= setup_addr + ADDR_W'(1);
                        state    <= RD_ISSUE;
                     end
                  end
               end else if (cpu_rd && !port_sel) begin
                  second   <= 1'b0;
                  cpu_dout <= rd_buf;
                  vga_addr <= ptr;
                  vga_rd   <= 1'b1;
                  ptr      <= ptr + ADDR_W'(1);
                  state    <= RD_ISSUE;
               end else if (cpu_rd && port_sel) begin
                  second   <= 1'b0;
                  cpu_dout <= {flag, 7'b0};
                  flag     <= 1'b0;
               end
            end
            WRITE: state <= IDLE;
            RD_ISSUE: state <= RD_CAPTURE;
            RD_CAPTURE: begin
               rd_buf <= vga_dout;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
         // A coincident frame edge overrides the status-read clear
         if (edge_q) flag <= 1'b1;
      end
   end

   // Configuration decode straight from the register file
   always_comb begin
      mode = 2'd1;
      if (regs[1][4])      mode = 2'd0;
      else if (regs[0][1]) mode = 2'd2;
      else if (regs[1][3]) mode = 2'd3;
   end

   assign busy                      = (state != IDLE);
   assign n_int                     = ~(flag & regs[1][5]);
   assign video_on                  = regs[1][6];
   assign name_table_addr           = {regs[2][3:0], 10'b0};
   assign color_table_addr          = {regs[3], 6'b0};
   assign font_addr                 = {regs[4][2:0], 11'b0};
   assign sprite_attr_addr          = {regs[5][6:0], 7'b0};
   assign sprite_pattern_table_addr = {regs[6][2:0], 11'b0};
   assign text_color                = regs[7][7:4];
   assign back_color                = regs[7][3:0];

endmodule

// File: tb/tb_vdp_ports.sv
// tb_vdp_ports: directed bench for vdp_ports with a small VRAM model.
// Expected values are hand-computed constants.
module tb_vdp_ports;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  cpu_din = 8'h00;
   logic [7:0]  cpu_dout;
   logic        port_sel = 1'b0;
   logic        cpu_wr = 1'b0;
   logic        cpu_rd = 1'b0;
   logic        busy;
   logic [13:0] vga_addr;
   logic [7:0]  vga_din;
   logic        vga_wr;
   logic        vga_rd;
   logic [7:0]  vga_dout = 8'h00;
   logic        frame_n_int = 1'b1;
   logic        n_int;
   logic [1:0]  mode;
   logic        video_on;
   logic [13:0] name_table_addr;
   logic [13:0] font_addr;
   logic [13:0] color_table_addr;
   logic [13:0] sprite_attr_addr;
   logic [13:0] sprite_pattern_table_addr;
   logic [3:0]  text_color;
   logic [3:0]  back_color;

   int total = 0;
   int bad = 0;

   logic [7:0] mem [0:16383];

   vdp_ports #(.ADDR_W(14)) dut (
      .clk(clk),
      .reset(reset),
      .cpu_din(cpu_din),
      .cpu_dout(cpu_dout),
      .port_sel(port_sel),
      .cpu_wr(cpu_wr),
      .cpu_rd(cpu_rd),
      .busy(busy),
      .vga_addr(vga_addr),
      .vga_din(vga_din),
      .vga_wr(vga_wr),
      .vga_rd(vga_rd),
      .vga_dout(vga_dout),
      .frame_n_int(frame_n_int),
      .n_int(n_int),
      .mode(mode),
      .video_on(video_on),
      .name_table_addr(name_table_addr),
      .font_addr(font_addr),
      .color_table_addr(color_table_addr),
      .sprite_attr_addr(sprite_attr_addr),
      .sprite_pattern_table_addr(sprite_pattern_table_addr),
      .text_color(text_color),
      .back_color(back_color)
   );

   always #5 clk = ~clk;

   // VRAM: synchronous write, read data one cycle after vga_rd
   always @(posedge clk) begin
      if (vga_wr) mem[vga_addr] <= vga_din;
      if (vga_rd) vga_dout <= mem[vga_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One-cycle strobe; returns at the negedge of the cycle after it
   task automatic strobe(input logic port, input logic wr,
                         input logic [7:0] d);
      @(negedge clk);
      port_sel = port;
      cpu_din  = d;
      cpu_wr   = wr;
      cpu_rd   = ~wr;
      @(negedge clk);
      cpu_wr = 1'b0;
      cpu_rd = 1'b0;
   endtask

   task automatic gap();
      repeat (3) @(negedge clk);
   endtask

   task automatic ctl(input logic [7:0] d);
      strobe(1'b1, 1'b1, d);
      gap();
   endtask

   task automatic dwr(input logic [7:0] d);
      strobe(1'b0, 1'b1, d);
      gap();
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_n_int", n_int, 1);
      chk("rst_busy", busy, 0);
      chk("rst_vga_wr", vga_wr, 0);
      chk("rst_vga_rd", vga_rd, 0);
      chk("rst_cpu_dout", cpu_dout, 8'h00);
      chk("rst_mode", mode, 2'd1);
      chk("rst_video_on", video_on, 0);
      chk("rst_name", name_table_addr, 14'h0000);
      chk("rst_colors", {text_color, back_color}, 8'h00);
      reset = 1'b0;
      gap();

      // Pointer 0x0000 with write setup, then two data writes
      ctl(8'h00);
      ctl(8'h40);
      chk("wsetup_no_busy", busy, 0);
      strobe(1'b0, 1'b1, 8'hAA);
      chk("w0_strobe", vga_wr, 1);
      chk("w0_addr", vga_addr, 14'h0000);
      chk("w0_din", vga_din, 8'hAA);
      chk("w0_busy", busy, 1);
      gap();
      chk("w0_idle", {busy, vga_wr}, 2'b00);
      strobe(1'b0, 1'b1, 8'h55);
      chk("w1_addr", vga_addr, 14'h0001);
      gap();
      dwr(8'h11);
      chk("mem0", mem[0], 8'hAA);
      chk("mem1", mem[1], 8'h55);
      chk("mem2_ptr2", mem[2], 8'h11);

      // Pointer wrap at 0x3FFF
      ctl(8'hFF);
      ctl(8'h7F);
      dwr(8'h01);
      dwr(8'h02);
      chk("mem3fff", mem[14'h3FFF], 8'h01);
      chk("wrap_mem0", mem[0], 8'h02);

      // Preload 0x1234/0x1235 through the data port
      ctl(8'h34);
      ctl(8'h52);
      dwr(8'h5A);
      dwr(8'hC3);

      // Read setup at 0x1234 issues a prefetch
      strobe(1'b1, 1'b1, 8'h34);
      gap();
      strobe(1'b1, 1'b1, 8'h12);
      chk("pf_vga_rd", vga_rd, 1);
      chk("pf_addr", vga_addr, 14'h1234);
      chk("pf_busy", busy, 1);
      gap();
      chk("pf_done", busy, 0);
      strobe(1'b0, 1'b0, 8'h00);
      chk("rd0", cpu_dout, 8'h5A);
      chk("rd0_addr", vga_addr, 14'h1235);
      gap();
      strobe(1'b0, 1'b0, 8'h00);
      chk("rd1", cpu_dout, 8'hC3);
      gap();

      // Register writes
      ctl(8'hF0); ctl(8'h81);
      ctl(8'h06); ctl(8'h82);
      ctl(8'h01); ctl(8'h84);
      ctl(8'h36); ctl(8'h85);
      ctl(8'h07); ctl(8'h86);
      ctl(8'hF4); ctl(8'h87);
      chk("video_on", video_on, 1);
      chk("mode_text", mode, 2'd0);
      chk("name", name_table_addr, 14'h1800);
      chk("font", font_addr, 14'h0800);
      chk("spr_attr", sprite_attr_addr, 14'h1B00);
      chk("spr_pat", sprite_pattern_table_addr, 14'h3800);
      chk("text_color", text_color, 4'hF);
      chk("back_color", back_color, 4'h4);
      ctl(8'hFF); ctl(8'h83);
      chk("color_tbl", color_table_addr, 14'h3FC0);

      // Mode priority: M2 alone, then M3 over M2
      ctl(8'h08); ctl(8'h81);
      chk("mode_mc", mode, 2'd3);
      ctl(8'h02); ctl(8'h80);
      chk("mode_g2", mode, 2'd2);
      ctl(8'h00); ctl(8'h80);
      ctl(8'hF0); ctl(8'h81);
      chk("mode_back", mode, 2'd0);

      // Frame interrupt: n_int low two cycles after the edge
      @(negedge clk);
      frame_n_int = 1'b0;
      @(negedge clk);
      chk("int_1cyc", n_int, 1);
      @(negedge clk);
      chk("int_2cyc", n_int, 0);
      frame_n_int = 1'b1;
      gap();
      strobe(1'b1, 1'b0, 8'h00);
      chk("status_80", cpu_dout, 8'h80);
      chk("int_cleared", n_int, 1);
      gap();

      // Frame edge coincident with status read: set wins
      @(negedge clk);
      frame_n_int = 1'b0;
      @(negedge clk);
      port_sel = 1'b1;
      cpu_rd   = 1'b1;
      frame_n_int = 1'b1;
      @(negedge clk);
      cpu_rd = 1'b0;
      chk("coinc_status", cpu_dout, 8'h00);
      chk("coinc_n_int", n_int, 0);
      gap();
      strobe(1'b1, 1'b0, 8'h00);
      chk("coinc_status2", cpu_dout, 8'h80);
      chk("coinc_clear", n_int, 1);
      gap();

      // Status read resets the two-write sequence
      ctl(8'h12);
      strobe(1'b1, 1'b0, 8'h00);
      gap();
      ctl(8'h00);
      ctl(8'h40);
      strobe(1'b0, 1'b1, 8'h77);
      chk("latch_reset_addr", vga_addr, 14'h0000);
      chk("latch_reset_wr", vga_wr, 1);
      gap();

      // Reset mid-access aborts it
      strobe(1'b0, 1'b1, 8'h99);
      reset = 1'b1;
      #1;
      chk("abort_wr", vga_wr, 0);
      chk("abort_busy", busy, 0);
      chk("abort_mode", mode, 2'd1);
      @(negedge clk);
      reset = 1'b0;
      gap();
      dwr(8'h3C);
      chk("abort_ptr0", mem[0], 8'h3C);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/vdp_ports.md
# vdp_ports

CPU-facing TMS9918-style port front end of the video subsystem. It decodes Z80 accesses to the VDP data port (0x98) and control port (0x99). It owns the 14-bit VRAM access pointer, the read-ahead buffer, registers R0–R7 and the status/interrupt flag. It drives the CPU-side VRAM port and all table-base, mode and colour inputs of the `video` display block, and turns its frame pulse into the CPU interrupt.

## Interface
Parameters:
- ADDR_W, 14, VRAM pointer width.

Ports:
- clk  in  1  system clock; same clock as the VRAM CPU port.
- reset  in  1  asynchronous, active-high.
- cpu_din  in  8  CPU write data.
- cpu_dout  out  8  CPU read data; valid the cycle after cpu_rd and held until the next cpu_rd.
- port_sel  in  1  0 = data port, 1 = control/status port.
- cpu_wr, cpu_rd  in  1  single-cycle access strobes.
- busy  out  1  high while a VRAM access or prefetch is in flight.
- vga_addr  out  14  VRAM address.
- vga_din  out  8  VRAM write data.
- vga_wr, vga_rd  out  1  VRAM strobes, one cycle each.
- vga_dout  in  8  VRAM read data, valid the cycle after vga_rd.
- frame_n_int  in  1  active-low frame pulse from `video`.
- n_int  out  1  active-low interrupt to the CPU.
- mode  out  2  0 text, 1 graphics I, 2 graphics II, 3 multicolour.
- video_on  out  1  R1 bit 6.
- name_table_addr, font_addr, color_table_addr, sprite_attr_addr, sprite_pattern_table_addr  out  14  table bases.
- text_color, back_color  out  4  R7[7:4], R7[3:0].

## Operation
- The control port takes two writes. The first write stores cpu_din in `latch` and sets `second`.
- Second control write with bit 7 = 1: register write, R[cpu_din[2:0]] <= latch.
- Second control write with bit 7 = 0: ptr <= {cpu_din[5:0], latch}. If bit 6 = 0, a prefetch is also issued (read setup).
- Any data-port access or status read clears `second`.
- Data write: vga_addr = ptr, vga_din = cpu_din, vga_wr for one cycle. Then buf <= cpu_din and ptr <= ptr + 1.
- Data read: cpu_dout <= buf, then a prefetch is issued.
- Prefetch: vga_rd at ptr in cycle N. buf <= vga_dout in cycle N+1. ptr increments in cycle N.
- ptr wraps from 0x3FFF to 0x0000.
- Status read: cpu_dout <= {F, 7'b0}, then F is cleared.
- F is set on the falling edge of frame_n_int (edge-detected with a registered copy).
- n_int = !(F & R1[5]).
- If a frame edge and a status read occur in the same cycle, the set wins: the returned byte has F = 0 and F ends at 1.
- Mode decode:
  - R1[4] (M1) set gives mode 0.
  - Otherwise R0[1] (M3) set gives mode 2.
  - Otherwise R1[3] (M2) set gives mode 3.
  - Otherwise mode 1.
- Table bases:
  - name_table_addr = {R2[3:0], 10'b0}.
  - color_table_addr = {R3, 6'b0}.
  - font_addr = {R4[2:0], 11'b0}.
  - sprite_attr_addr = {R5[6:0], 7'b0}.
  - sprite_pattern_table_addr = {R6[2:0], 11'b0}.
- All configuration outputs are combinational decodes of the registers.
- FSM states:
  - IDLE
  - WRITE: 1 cycle, vga_wr.
  - RD_ISSUE: 1 cycle, vga_rd.
  - RD_CAPTURE: 1 cycle, buf load.
- Transitions: IDLE→WRITE on a data write; IDLE→RD_ISSUE on a data read or a read setup; WRITE→IDLE; RD_ISSUE→RD_CAPTURE→IDLE.
- busy = (state != IDLE).

## Timing
- Reset values:
  - All registers 0. Resulting outputs: mode 1, video_on 0, all table bases 0, colours 0.
  - ptr 0, buf 0, latch 0, second 0, F 0, state IDLE.
  - vga_wr and vga_rd 0, cpu_dout 0, n_int 1, busy 0.
- Reset mid-access aborts the access immediately. No partial ptr increment survives.
- Register writes take effect on the next clock edge.
- Data write: vga_wr asserted the cycle after cpu_wr.
- Data read: cpu_dout updates 1 cycle after cpu_rd. The new buf is loaded 3 cycles after cpu_rd.
- Strobes arriving while busy = 1 are ignored. The CPU interface guarantees a spacing of at least 4 cycles.
- n_int falls 2 cycles after the frame_n_int falling edge (edge detect plus F register). It rises 1 cycle after the status read.

## Test plan
- Reset, then write 0x00 then 0x40 to control, then data 0xAA, 0x55 → vga_wr at 0x0000 = 0xAA and at 0x0001 = 0x55; ptr ends at 0x0002.
- Pointer set to 0x3FFF with bit 6 set, then two data writes → second write lands at 0x0000.
- Preload VRAM[0x1234] = 0x5A and [0x1235] = 0xC3. Write 0x34 then 0x12 to control → prefetch. Two data reads return 0x5A then 0xC3.
- Register writes (0xF0,0x81) (0x06,0x82) (0x01,0x84) (0x36,0x85) (0x07,0x86) (0xF4,0x87):
  - video_on = 1, IE = 1, mode 0.
  - name_table_addr 0x1800, font_addr 0x0800, sprite_attr_addr 0x1B00, sprite_pattern_table_addr 0x3800.
  - text_color 0xF, back_color 0x4.
- IE set, pulse frame_n_int low → n_int low after 2 cycles. Status read returns 0x80; n_int high next cycle. A frame edge coincident with the status read leaves n_int low.
- Single control write 0x12, then status read, then control write 0x00, 0x40 → ptr = 0x0000 (latch reset by the status read).
